seq_onehot_left_shifter: RTL and testbench

- Multi-cycle logical left shifter. Shift amount is given as a one-hot (or multi-hot) mask.
- Complements the existing combinational one-hot right barrel shifter: same mask encoding, opposite shift direction.
- Iterates over the mask one bit per clock, reusing a single AND-OR accumulate stage instead of a full array.
- Sits between a register-file read port and the writeback mux. A start/busy/done handshake sequences it.

---
 rtl/seq_shift_pkg.sv | 14 +
 rtl/shl_ao_stage.sv | 19 +
 rtl/seq_onehot_left_shifter.sv | 115 +++++++++++
 tb/tb_seq_onehot_left_shifter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_pkg.sv
// Shared definitions for the sequential one-hot left shifter.
//   state_t   : controller state encoding (IDLE, SHIFT, DONE), 2 bits
//   DEF_WIDTH : default data / mask width
package seq_shift_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : seq_shift_pkg

// File: rtl/shl_ao_stage.sv
// Single AND-OR accumulate cell of the left shifter: folds the currently
// shifted operand into the accumulator when the selecting mask bit is set.
// Same cell shape as the combinational right shifter.
//   acc     : running OR of already selected shifts
//   sh      : operand shifted by the current step index
//   sel     : mask bit for the current step
//   acc_nxt : acc | (sh & {WIDTH{sel}})
module shl_ao_stage #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sh,
  input  logic             sel,
  output logic [WIDTH-1:0] acc_nxt
);

  assign acc_nxt = acc | (sh & {WIDTH{sel}});

endmodule : shl_ao_stage

// File: rtl/seq_onehot_left_shifter.sv
// Multi-cycle logical left shifter with a one-hot / multi-hot shift mask.
// One mask bit is consumed per clock through a shared AND-OR stage, so an
// operation always takes WIDTH SHIFT cycles followed by one DONE cycle.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; w holds the previous result
//   SHIFT | one mask bit per cycle folded into acc; busy=1
//   DONE  | w just loaded, done=1; start here chains the next operation
//
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled only in IDLE or DONE
//   d     : operand, captured on accepted start
//   n     : shift mask, bit j selects a left shift by j
//   w     : result, stable from done until the next result is produced
//   busy  : operation in progress
//   done  : single-cycle pulse, w valid
module seq_onehot_left_shifter
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] w,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   sh_reg;
  logic [WIDTH-1:0]   mask_reg;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   w_q;
  logic               load;
  logic               last_step;

  shl_ao_stage #(
    .WIDTH (WIDTH)
  ) u_ao_stage (
    .acc     (acc),
    .sh      (sh_reg),
    .sel     (mask_reg[0]),
    .acc_nxt (acc_nxt)
  );

  assign last_step = (state_q == SHIFT) && (cnt == CNT_LAST);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_reg   <= '0;
      mask_reg <= '0;
      acc      <= '0;
      cnt      <= '0;
      w_q      <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sh_reg   <= d;
        mask_reg <= n;
        acc      <= '0;
        cnt      <= '0;
      end else if (state_q == SHIFT) begin
        acc      <= acc_nxt;
        sh_reg   <= sh_reg << 1;
        mask_reg <= mask_reg >> 1;
        cnt      <= cnt + 1'b1;
      end
      // Take the post-step accumulator so the final mask bit is included.
      if (last_step) w_q <= acc_nxt;
    end
  end

  assign w    = w_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule : seq_onehot_left_shifter

// File: tb/tb_seq_onehot_left_shifter.sv
module tb_seq_onehot_left_shifter;

  localparam int WIDTH = 16;
  localparam int LAT_EDGES = 17;  // accept edge through the edge entering DONE
  localparam int TIMEOUT = 60;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] w;
  logic             busy;
  logic             done;

  int n_checks;
  int n_fail;

  seq_onehot_left_shifter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .d     (d),
    .n     (n),
    .w     (w),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: OR of d shifted left by every selected mask position.
  function automatic logic [WIDTH-1:0] ref_shl(input logic [WIDTH-1:0] dv,
                                               input logic [WIDTH-1:0] nv);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < WIDTH; j++)
      if (nv[j]) r = r | ({{WIDTH{1'b0}}, dv} << j);
    return r[WIDTH-1:0];
  endfunction

  // Launch one op from IDLE, wait for done. Inputs change on negedge,
  // outputs sampled on negedge. edges counts rising edges from the accept
  // edge (inclusive) to the one that raised done.
  task automatic run_op(input logic [WIDTH-1:0] dv, input logic [WIDTH-1:0] nv,
                        output logic [WIDTH-1:0] res, output int edges,
                        output int busy_cycles);
    @(negedge clk);
    d = dv; n = nv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; d = WIDTH'($urandom); n = WIDTH'($urandom);
    edges = 1; busy_cycles = 0;
    while (!done && edges < TIMEOUT) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      edges++;
    end
    res = w;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; d = 16'hFFFF; n = 16'h0001;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || w !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b w=%h required busy=0 done=0 w=0000",
               busy, done, w);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] dv [6] = '{16'h0001, 16'h8421, 16'hFFFF, 16'hABCD, 16'hABCD, 16'h0001};
    logic [WIDTH-1:0] nv [6] = '{16'h0010, 16'h0002, 16'h8000, 16'h0000, 16'h0001, 16'h0003};
    logic [WIDTH-1:0] ev [6] = '{16'h0010, 16'h0842, 16'h8000, 16'h0000, 16'hABCD, 16'h0003};
    logic [WIDTH-1:0] res;
    int edges, bc;
    for (int i = 0; i < 6; i++) begin
      run_op(dv[i], nv[i], res, edges, bc);
      n_checks++;
      if (res !== ev[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: d=%h n=%h w=%h required %h", i, dv[i], nv[i], res, ev[i]);
      end
      n_checks++;
      if (edges != LAT_EDGES) begin
        n_fail++;
        $display("FAIL latency_%0d: edges=%0d required %0d", i, edges, LAT_EDGES);
      end
      n_checks++;
      if (bc != WIDTH) begin
        n_fail++;
        $display("FAIL busy_cycles_%0d: %0d required %0d", i, bc, WIDTH);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse_%0d: done=%b busy=%b required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] dv, nv, res;
    int edges, bc;
    for (int i = 0; i < 200; i++) begin
      dv = WIDTH'($urandom);
      case (i % 4)
        0: nv = WIDTH'(1) << $urandom_range(WIDTH-1, 0);
        default: nv = WIDTH'($urandom);
      endcase
      run_op(dv, nv, res, edges, bc);
      n_checks++;
      if (res !== ref_shl(dv, nv) || edges != LAT_EDGES) begin
        n_fail++;
        $display("FAIL random_%0d: d=%h n=%h w=%h edges=%0d required w=%h edges=%0d",
                 i, dv, nv, res, edges, ref_shl(dv, nv), LAT_EDGES);
      end
    end
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] res, held;
    int edges, bc;
    run_op(16'h1234, 16'h0104, res, edges, bc);
    held = ref_shl(16'h1234, 16'h0104);
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (w !== held) begin
        n_fail++;
        $display("FAIL hold_idle: w=%h required %h", w, held);
      end
    end
    // Launch another op and check w does not move during SHIFT.
    d = 16'hFFFF; n = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (w !== held || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_shift: w=%h busy=%b required w=%h busy=1", w, busy, held);
    end
    edges = 0;
    while (!done && edges < TIMEOUT) begin
      @(negedge clk);
      edges++;
    end
    n_checks++;
    if (w !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL hold_next: w=%h required ffff", w);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] qd[$], qn[$];
    int cyc;
    for (int i = 0; i < 5; i++) begin
      qd.push_back(WIDTH'($urandom));
      qn.push_back(WIDTH'($urandom));
    end
    @(negedge clk);
    d = qd[0]; n = qn[0]; start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cyc = 1;
      while (!done && cyc < TIMEOUT) begin
        @(negedge clk);
        cyc++;
      end
      n_checks++;
      if (cyc != LAT_EDGES || w !== ref_shl(qd[i], qn[i])) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: period=%0d w=%h required period=%0d w=%h",
                 i, cyc, w, LAT_EDGES, ref_shl(qd[i], qn[i]));
      end
      if (i < 4) begin
        d = qd[i+1]; n = qn[i+1];
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_end: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_start_ignored();
    int edges;
    @(negedge clk);
    d = 16'h0F0F; n = 16'h0011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    repeat (4) begin @(negedge clk); edges++; end
    d = 16'hFFFF; n = 16'hFFFF; start = 1'b1;
    repeat (3) begin @(negedge clk); edges++; end
    start = 1'b0;
    while (!done && edges < TIMEOUT) begin
      @(negedge clk);
      edges++;
    end
    n_checks++;
    if (w !== ref_shl(16'h0F0F, 16'h0011) || edges != LAT_EDGES) begin
      n_fail++;
      $display("FAIL start_ignored: w=%h edges=%0d required w=%h edges=%0d",
               w, edges, ref_shl(16'h0F0F, 16'h0011), LAT_EDGES);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [WIDTH-1:0] res;
    int edges, bc;
    @(negedge clk);
    d = 16'h00FF; n = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || w !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b w=%h required 0 0 0000", busy, done, w);
    end
    bc = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) bc++;
    end
    n_checks++;
    if (bc != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: activity_cycles=%0d required 0", bc);
    end
    run_op(16'h0003, 16'h0040, res, edges, bc);
    n_checks++;
    if (res !== 16'h00C0 || edges != LAT_EDGES) begin
      n_fail++;
      $display("FAIL reset_recover: w=%h edges=%0d required 00c0 %0d", res, edges, LAT_EDGES);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1; start = 1'b0; d = '0; n = '0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_onehot_left_shifter
